eth_tx_preamble_ifg: RTL and testbench

- Transmit-side framing stage directly downstream of `tcp_sender`.
- Consumes the complete Ethernet frame byte stream produced by `tcp_sender`: destination MAC through CRC32, `tlast` on the final CRC byte.
- Prepends the 7-byte preamble and SFD, enforces the inter-frame gap, and truncates runaway frames.
- Feeds the PHY-side byte adapter over AXI-Stream.

---
 rtl/eth_tx_preamble_ifg_pkg.sv | 18 +
 rtl/axi_stream_if.sv | 12 +
 rtl/eth_tx_preamble_ifg.sv | 144 ++++++++++++++
 tb/tb_eth_tx_preamble_ifg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_preamble_ifg_pkg.sv
// Shared Ethernet transmit framing definitions: state encoding and preamble/SFD/IFG constants.
package eth_tx_preamble_ifg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_DROP,
    ST_IFG
  } eth_tx_state_e;

  localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;
  localparam int         ETH_PREAMBLE_LEN  = 7;
  localparam int         ETH_DEFAULT_IFG   = 12;

endpackage

// File: rtl/axi_stream_if.sv
// Byte-stream AXI-Stream bundle used between the TCP sender, framer and PHY adapter.
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_tx_preamble_ifg.sv
// Prepends preamble/SFD, truncates runaway frames and enforces the inter-frame gap.
// Optional statistics counters are enabled with ETH_TX_STATS_EN.
module eth_tx_preamble_ifg
  import eth_tx_preamble_ifg_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int IFG_BYTES       = ETH_DEFAULT_IFG,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic         clk,
  input  logic         rst_n,
  axi_stream_if.slave  s_axis,
  axi_stream_if.master m_axis,
  output logic         busy,
  output logic         oversize
`ifdef ETH_TX_STATS_EN
  ,
  output logic [31:0]  frame_count,
  output logic [31:0]  byte_count,
  output logic [15:0]  oversize_count
`endif
);

  localparam int IW = $clog2(IFG_BYTES + 1);

  eth_tx_state_e         state, state_nxt;
  logic [2:0]            pre_cnt;
  logic [10:0]           byte_cnt;
  logic [IW-1:0]         ifg_cnt;
  logic                  drop_seen;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid, out_last;
  logic                  s_ready, load, trunc, out_hs, enter_ifg;

  assign out_hs    = out_valid && m_axis.tready;
  assign enter_ifg = (state != ST_IFG) && (state_nxt == ST_IFG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    load      = 1'b0;
    trunc     = 1'b0;
    case (state)
      ST_IDLE: if (s_axis.tvalid) state_nxt = ST_PRE;
      ST_PRE:  if (out_hs && pre_cnt == 3'(ETH_PREAMBLE_LEN - 1)) state_nxt = ST_SFD;
      ST_SFD, ST_DATA: begin
        // The SFD sits in the output slot, so the first byte can load on its handshake.
        s_ready = !out_valid || (m_axis.tready && !out_last);
        load    = s_axis.tvalid && s_ready;
        trunc   = load && !s_axis.tlast && (byte_cnt == 11'(MAX_FRAME_BYTES - 1));
        if (state == ST_SFD && out_hs) state_nxt = ST_DATA;
        if (out_hs && out_last)        state_nxt = ST_IFG;
        if (trunc)                     state_nxt = ST_DROP;
      end
      ST_DROP: begin
        // The truncated final beat may still be draining from the slot.
        s_ready = 1'b1;
        if ((drop_seen || (s_axis.tvalid && s_axis.tlast)) && (!out_valid || out_hs))
          state_nxt = ST_IFG;
      end
      // The IDLE cycle that follows counts towards the gap.
      ST_IFG:  if (ifg_cnt <= IW'(1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      pre_cnt   <= '0;
      byte_cnt  <= '0;
      ifg_cnt   <= '0;
      drop_seen <= 1'b0;
      oversize  <= 1'b0;
    end else begin
      oversize <= trunc;
      if (enter_ifg) ifg_cnt <= IW'(IFG_BYTES - 1);
      case (state)
        ST_IDLE: if (s_axis.tvalid) begin
          out_data  <= DATA_WIDTH'(ETH_PREAMBLE_BYTE);
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          pre_cnt   <= '0;
          byte_cnt  <= '0;
          drop_seen <= 1'b0;
        end
        ST_PRE: if (out_hs) begin
          pre_cnt <= pre_cnt + 3'd1;
          if (pre_cnt == 3'(ETH_PREAMBLE_LEN - 1)) out_data <= DATA_WIDTH'(ETH_SFD_BYTE);
        end
        ST_SFD, ST_DATA: begin
          if (load) begin
            out_data  <= s_axis.tdata;
            out_valid <= 1'b1;
            out_last  <= s_axis.tlast || trunc;
            byte_cnt  <= byte_cnt + 11'd1;
          end else if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        ST_DROP: begin
          if (s_axis.tvalid && s_axis.tlast) drop_seen <= 1'b1;
          if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        ST_IFG: if (ifg_cnt != '0) ifg_cnt <= ifg_cnt - IW'(1);
        default: ;
      endcase
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = out_data;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = out_last;
  assign busy          = (state != ST_IDLE);

`ifdef ETH_TX_STATS_EN
  generate
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        frame_count    <= '0;
        byte_count     <= '0;
        oversize_count <= '0;
      end else begin
        if (enter_ifg) frame_count    <= frame_count + 32'd1;
        if (load)      byte_count     <= byte_count + 32'd1;
        if (trunc)     oversize_count <= oversize_count + 16'd1;
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_eth_tx_preamble_ifg.sv
// Randomized bench for eth_tx_preamble_ifg against a frame-level reference model.
module tb_eth_tx_preamble_ifg;
  localparam int MAXB = 1518;
  localparam int IFG  = 12;

  logic clk, rst_n, busy, oversize;
`ifdef ETH_TX_STATS_EN
  logic [31:0] frame_count, byte_count;
  logic [15:0] oversize_count;
`endif

  axi_stream_if #(.DATA_WIDTH(8)) s_if ();
  axi_stream_if #(.DATA_WIDTH(8)) m_if ();

  eth_tx_preamble_ifg #(.DATA_WIDTH(8), .IFG_BYTES(IFG), .MAX_FRAME_BYTES(MAXB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_axis   (s_if),
    .m_axis   (m_if),
    .busy     (busy),
    .oversize (oversize)
`ifdef ETH_TX_STATS_EN
    ,
    .frame_count    (frame_count),
    .byte_count     (byte_count),
    .oversize_count (oversize_count)
`endif
  );

  int n_checks = 0, n_err = 0;
  int n_beats = 0, n_over = 0, cyc = 0, last_cyc = 0, last_gap = -1;
  bit have_last = 0, prev_valid = 0, stall_prev = 0, rdy_rand = 0, abort = 0;
  logic [8:0] prev_beat = '0;
  logic [8:0] exp_q[$];
  int exp_frames = 0, exp_bytes = 0, exp_over = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard, stall stability, oversize pulses, gap measurement.
  always @(negedge clk) begin
    logic [8:0] got, e;
    cyc++;
    if (oversize) n_over++;
    if (stall_prev) chk("stall_hold", {m_if.tvalid, m_if.tlast, m_if.tdata}, {1'b1, prev_beat});
    if (m_if.tvalid && !prev_valid && have_last) last_gap = cyc - last_cyc - 1;
    if (m_if.tvalid && m_if.tready) begin
      n_beats++;
      got = {m_if.tlast, m_if.tdata};
      if (exp_q.size() == 0) chk("extra_beat", {23'd0, got}, 32'hDEAD_BEEF);
      else begin
        e = exp_q.pop_front();
        chk("beat", {23'd0, got}, {23'd0, e});
      end
      if (m_if.tlast) begin
        last_cyc  = cyc;
        have_last = 1;
      end
    end
    stall_prev = m_if.tvalid && !m_if.tready;
    prev_beat  = {m_if.tlast, m_if.tdata};
    prev_valid = m_if.tvalid;
  end

  // Sends an n-byte frame (tlast on byte n) and queues the framed bytes the PHY must see.
  task automatic send(input int n, input bit gaps);
    int  fwd;
    bit  hs;
    int  guard;
    logic [7:0] d;
    fwd = (n > MAXB) ? MAXB : n;
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    for (int i = 0; i < n; i++) begin
      if (abort) break;
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        s_if.tvalid = 1'b0;
        @(posedge clk); #1;
      end
      d = 8'($urandom_range(0, 255));
      if (i < fwd) exp_q.push_back({(i == fwd - 1), d});
      s_if.tdata  = d;
      s_if.tvalid = 1'b1;
      s_if.tlast  = (i == n - 1);
      hs = 0;
      guard = 0;
      while (!hs && !abort && guard < 400) begin
        @(negedge clk);
        hs = s_if.tready;
        guard++;
      end
      if (!hs && !abort) begin
        chk("in_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    if (!abort) begin
      exp_frames++;
      exp_bytes += fwd;
      if (n > MAXB) exp_over++;
    end
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 20000) begin
      @(posedge clk);
      g++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tvalid"}, m_if.tvalid, 0);
    chk({tag, "_tdata"}, m_if.tdata, 0);
    chk({tag, "_tlast"}, m_if.tlast, 0);
    chk({tag, "_tready"}, s_if.tready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_oversize"}, oversize, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_reset_vals("init");
`ifdef ETH_TX_STATS_EN
    chk("init_frames", frame_count, 0);
    chk("init_bytes", byte_count, 0);
    chk("init_ovc", oversize_count, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a frame, at data byte 20.
    n_beats = 0;
    fork send(100, 0); join_none
    g = 0;
    while (n_beats < 28 && g < 1000) begin @(posedge clk); g++; end
    chk("rst_reach", n_beats >= 28, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    abort = 1;
    #1;
    chk_reset_vals("midrst");
    exp_q.delete();
    exp_frames = 0; exp_bytes = 0; exp_over = 0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    abort = 0;
    @(posedge clk); #1;

    // Clean frame after reset: 58 bytes, tready always high.
    n_beats = 0; n_over = 0;
    send(58, 0);
    drain();
    chk("t58_beats", n_beats, 66);
    chk("t58_over", n_over, 0);

    // Back-to-back frames: exact gap.
    n_beats = 0;
    send(60, 0);
    send(64, 0);
    drain();
    chk("b2b_beats", n_beats, 140);
    chk("b2b_gap", last_gap, IFG);

    // Random backpressure and input gaps.
    n_beats = 0; n_over = 0;
    rdy_rand = 1;
    send(1058, 1);
    drain();
    chk("t1058_beats", n_beats, 1066);
    chk("t1058_over", n_over, 0);

    // Runaway frame truncated at MAXB bytes.
    n_beats = 0; n_over = 0;
    send(1600, 1);
    drain();
    rdy_rand = 0;
    chk("t1600_beats", n_beats, MAXB + 8);
    chk("t1600_over", n_over, 1);
    chk("t1600_idle", busy, 0);

    // A frame of exactly MAXB bytes ends normally.
    n_beats = 0; n_over = 0;
    send(MAXB, 0);
    drain();
    chk("tmax_beats", n_beats, MAXB + 8);
    chk("tmax_over", n_over, 0);

`ifdef ETH_TX_STATS_EN
    chk("st_frames", frame_count, exp_frames);
    chk("st_bytes", byte_count, exp_bytes);
    chk("st_ovc", oversize_count, exp_over);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
